// File: rtl/fetch_sequencer_pkg.sv
// Shared CPU definitions for the fetch sequencer.
// Contents:
//   - FSM state encodings (legacy 3-bit constants)
//   - opcode constants for the instructions that redirect control flow,
//     plus the other base opcodes that carry an immediate
//   - imm_fmt_e and imm_format(): map an opcode to its immediate layout
package fetch_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_UPDATE = 3'd4;
    localparam logic [2:0] ST_FAULT  = 3'd5;

    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J
    } imm_fmt_e;

    function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
        imm_fmt_e fmt;
        case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_JALR: fmt = FMT_I;
            OPC_STORE:                     fmt = FMT_S;
            OPC_BRANCH:                    fmt = FMT_B;
            OPC_LUI, OPC_AUIPC:            fmt = FMT_U;
            OPC_JAL:                       fmt = FMT_J;
            default:                       fmt = FMT_NONE;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory fetch bus.
//   imem_req   : sequencer -> memory, fetch request
//   imem_addr  : sequencer -> memory, fetch address
//   imem_ready : memory -> sequencer, imem_rdata valid this cycle
//   imem_rdata : memory -> sequencer, fetched instruction word
// master = sequencer side, slave = memory side.
interface fetch_sequencer_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer_imm_generator.sv
// Immediate generator: purely combinational decode of the instruction
// register into a sign-extended 32-bit immediate.
//   instr : instruction word
//   imm32 : decoded immediate (0 for opcodes without an immediate)
module imm_generator
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] instr,
    output logic [31:0] imm32
);

    always_comb begin
        imm32 = '0;
        case (imm_format(instr[6:0]))
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'b0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: multi-cycle control FSM that fetches an instruction,
// decodes its immediate, waits for the datapath, then computes the next pc.
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   imem          : fetch bus (master side), addr always equals pc
//   exec_done     : datapath finished the current instruction
//   branch_taken  : branch compare result, used only in UPDATE
//   rs1_data      : rs1 value, used only in UPDATE (jalr base)
//   pc, instr     : program counter and instruction register
//   imm32         : decoded immediate of instr
//   link_addr     : pc + 4
//   ir_valid      : instr/imm32 meaningful (DECODE, EXEC)
//   fault         : set in the terminal FAULT state
//   state         : FSM encoding, debug only
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic               clk,
    input  logic               rst,
    fetch_sequencer_if.master  imem,
    input  logic               exec_done,
    input  logic               branch_taken,
    input  logic [31:0]        rs1_data,
    output logic [31:0]        pc,
    output logic [31:0]        instr,
    output logic [31:0]        imm32,
    output logic [31:0]        link_addr,
    output logic               ir_valid,
    output logic               fault,
    output logic [2:0]         state
);

    // Counter value seen in the last allowed wait cycle.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0]         wait_cnt;
    logic [31:0]        next_pc;
    logic               misaligned;
    logic signed [31:0] jalr_off;
    logic [31:0]        jalr_sum;

    imm_generator u_imm (
        .instr (instr),
        .imm32 (imm32)
    );

    // jalr uses the raw I-field of instr, independent of the shared decoder.
    assign jalr_off = {{20{instr[31]}}, instr[31:20]};
    assign jalr_sum = rs1_data + $unsigned(jalr_off);

    always_comb begin
        next_pc = pc + 32'd4;
        case (instr[6:0])
            OPC_JAL:    next_pc = pc + imm32;
            OPC_JALR:   next_pc = {jalr_sum[31:1], 1'b0};
            OPC_BRANCH: next_pc = branch_taken ? (pc + imm32) : (pc + 32'd4);
            default:    next_pc = pc + 32'd4;
        endcase
    end

    assign misaligned = |next_pc[1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            instr    <= '0;
            wait_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    state    <= ST_FETCH;
                end
                ST_FETCH: begin
                    // A response in the final wait cycle still wins over timeout.
                    if (imem.imem_ready) begin
                        instr <= imem.imem_rdata;
                        state <= ST_DECODE;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state <= ST_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                ST_DECODE: begin
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (exec_done) begin
                        state <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    // A misaligned target leaves pc on the offending instruction.
                    if (misaligned) begin
                        state <= ST_FAULT;
                    end else begin
                        pc       <= next_pc;
                        wait_cnt <= '0;
                        state    <= ST_FETCH;
                    end
                end
                ST_FAULT: begin
                    state <= ST_FAULT;
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

    assign imem.imem_req  = (state == ST_FETCH);
    assign imem.imem_addr = pc;
    assign link_addr      = pc + 32'd4;
    assign ir_valid       = (state == ST_DECODE) || (state == ST_EXEC);
    assign fault          = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          TMO      = 16;

    localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                   S_UPDATE = 4, S_FAULT = 5;

    localparam logic [31:0] JALR_X1 = 32'h0000_8067;  // jalr x0, 0(x1)
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exec_done = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] rs1_data = '0;
    logic [31:0] pc, instr, imm32, link_addr;
    logic        ir_valid, fault;
    logic [2:0]  state;

    fetch_sequencer_if imem_bus ();

    fetch_sequencer #(
        .RESET_PC       (RESET_PC),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imem         (imem_bus),
        .exec_done    (exec_done),
        .branch_taken (branch_taken),
        .rs1_data     (rs1_data),
        .pc           (pc),
        .instr        (instr),
        .imm32        (imm32),
        .link_addr    (link_addr),
        .ir_valid     (ir_valid),
        .fault        (fault),
        .state        (state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [31:0] m_pc    = RESET_PC;
    logic [31:0] m_instr = '0;
    int          e_state = S_IDLE;
    bit          chk_en  = 0;
    bit          trace_en = 0;
    int          trace[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        if (v[bits-1]) return v - (32'd1 << bits);
        return v;
    endfunction

    // Immediate from the ISA field layout, assembled arithmetically.
    function automatic logic [31:0] m_imm(input logic [31:0] ins);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return sext(ins >> 20, 12);
            7'h23: return sext(((ins >> 25) << 5) + ((ins >> 7) & 32'd31), 12);
            7'h63: return sext((((ins >> 31) & 32'd1) << 12) + (((ins >> 7) & 32'd1) << 11)
                             + (((ins >> 25) & 32'd63) << 5) + (((ins >> 8) & 32'd15) << 1), 13);
            7'h37, 7'h17: return ins & 32'hFFFF_F000;
            7'h6F: return sext((((ins >> 31) & 32'd1) << 20) + (((ins >> 12) & 32'd255) << 12)
                             + (((ins >> 20) & 32'd1) << 11) + (((ins >> 21) & 32'd1023) << 1), 21);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] m_next(input logic [31:0] p, input logic [31:0] ins,
                                           input logic [31:0] rs1, input logic tk);
        case (ins[6:0])
            7'h6F: return p + m_imm(ins);
            7'h67: return (rs1 + sext(ins >> 20, 12)) & ~32'd1;
            7'h63: return tk ? p + m_imm(ins) : p + 32'd4;
            default: return p + 32'd4;
        endcase
    endfunction

    // Compare process: DUT vs model on every falling edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("state",     {29'd0, state}, e_state);
            check("imem_req",  {31'd0, imem_bus.imem_req}, (e_state == S_FETCH) ? 1 : 0);
            check("imem_addr", imem_bus.imem_addr, m_pc);
            check("pc",        pc, m_pc);
            check("link_addr", link_addr, m_pc + 32'd4);
            check("instr",     instr, m_instr);
            check("imm32",     imm32, m_imm(m_instr));
            check("ir_valid",  {31'd0, ir_valid}, (e_state == S_DECODE || e_state == S_EXEC) ? 1 : 0);
            check("fault",     {31'd0, fault}, (e_state == S_FAULT) ? 1 : 0);
            if (trace_en) trace.push_back(int'(state));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic noise();
        imem_bus.imem_ready = 1'($urandom);
        imem_bus.imem_rdata = $urandom;
        exec_done    = 1'($urandom);
        branch_taken = 1'($urandom);
        rs1_data     = $urandom;
    endtask

    task automatic do_reset();
        #2;
        rst    = 1'b1;
        chk_en = 0;
        #1;
        check("rst_state",  {29'd0, state}, S_IDLE);
        check("rst_pc",     pc, RESET_PC);
        check("rst_instr",  instr, 32'd0);
        check("rst_imm32",  imm32, 32'd0);
        check("rst_req",    {31'd0, imem_bus.imem_req}, 0);
        check("rst_irv",    {31'd0, ir_valid}, 0);
        check("rst_fault",  {31'd0, fault}, 0);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_pc    = RESET_PC;
        m_instr = '0;
        e_state = S_IDLE;
        chk_en  = 1;
        noise();
        tick();
        e_state = S_FETCH;
        imem_bus.imem_ready = 1'b0;
    endtask

    task automatic fault_hold(input int n);
        for (int i = 0; i < n; i++) begin
            e_state = S_FAULT;
            noise();
            tick();
        end
    endtask

    // One instruction from its first FETCH cycle. fwait = cycles without
    // ready before it arrives (>= TMO means it never does). abort_at: 1 =
    // reset in the 3rd FETCH cycle, 2 = reset in the 2nd EXEC cycle.
    task automatic do_instr(input logic [31:0] ins, input int fwait, input int ewait,
                            input logic [31:0] rs1, input logic tk, input int abort_at,
                            output bit faulted);
        logic [31:0] nxt;
        faulted = 0;
        for (int k = 1; k <= TMO; k++) begin
            e_state = S_FETCH;
            noise();
            imem_bus.imem_ready = (k == fwait + 1);
            if (k == fwait + 1) imem_bus.imem_rdata = ins;
            if (abort_at == 1 && k == 3) begin
                do_reset();
                return;
            end
            tick();
            if (k == fwait + 1) begin
                m_instr = ins;
                break;
            end
            if (k == TMO) begin
                faulted = 1;
                e_state = S_FAULT;
                return;
            end
        end
        e_state = S_DECODE;
        noise();
        exec_done = 1'b0;
        tick();
        for (int j = 1; j <= ewait + 1; j++) begin
            e_state = S_EXEC;
            noise();
            exec_done = (j == ewait + 1);
            if (abort_at == 2 && j == 2) begin
                do_reset();
                return;
            end
            tick();
        end
        e_state = S_UPDATE;
        noise();
        rs1_data     = rs1;
        branch_taken = tk;
        tick();
        nxt = m_next(m_pc, ins, rs1, tk);
        if (nxt[1:0] != 2'b00) begin
            faulted = 1;
            e_state = S_FAULT;
        end else begin
            m_pc    = nxt;
            e_state = S_FETCH;
        end
        imem_bus.imem_ready = 1'b0;
    endtask

    task automatic goto(input logic [31:0] addr);
        bit f;
        do_instr(JALR_X1, 0, 0, addr, 1'b0, 0, f);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit          f;
        logic [31:0] ins, rs1;
        int          kind, fw, ew, ab, r;
        logic        tk;
        bit          mis;
        int          exp_trace[9] = '{0, 1, 1, 1, 2, 3, 3, 4, 1};

        imem_bus.imem_ready = 1'b0;
        imem_bus.imem_rdata = '0;

        // Model pins against hand-decoded immediates
        check("model_jal_imm", m_imm(32'hFF9F_F06F), 32'hFFFF_FFF8);
        check("model_beq_imm", m_imm(32'h0000_0863), 32'h0000_0010);

        // Basic sequence with state trace
        trace_en = 1;
        do_reset();
        do_instr(NOP, 2, 1, 32'd0, 1'b0, 0, f);
        @(negedge clk);
        #1;
        trace_en = 0;
        check("trace_len", trace.size(), 9);
        for (int i = 0; i < 9 && i < trace.size(); i++)
            check("trace_state", trace[i], exp_trace[i]);
        check("seq_pc", pc, 32'h4);

        // jal backwards
        goto(32'h100);
        check("jal_pc_before", pc, 32'h100);
        check("jal_link", link_addr, 32'h104);
        do_instr(32'hFF9F_F06F, 1, 0, 32'd0, 1'b0, 0, f);
        check("jal_pc_after", pc, 32'hF8);

        // beq taken / not taken
        goto(32'h40);
        do_instr(32'h0000_0863, 0, 1, 32'd0, 1'b1, 0, f);
        check("beq_taken_pc", pc, 32'h50);
        goto(32'h40);
        do_instr(32'h0000_0863, 0, 1, 32'd0, 1'b0, 0, f);
        check("beq_ntaken_pc", pc, 32'h44);

        // Sequential wrap at the top of the address space
        goto(32'hFFFF_FFFC);
        do_instr(NOP, 0, 0, 32'd0, 1'b0, 0, f);
        check("wrap_pc", pc, 32'h0);
        check("wrap_fault", {31'd0, fault}, 0);

        // Misaligned jalr target
        goto(32'h80);
        do_instr(JALR_X1, 0, 0, 32'h203, 1'b0, 0, f);
        check("jalr_mis_state", {29'd0, state}, S_FAULT);
        check("jalr_mis_fault", {31'd0, fault}, 1);
        check("jalr_mis_pc", pc, 32'h80);
        fault_hold(3);
        do_reset();

        // Fetch timeout, then response in the last allowed cycle
        do_instr(NOP, TMO, 0, 32'd0, 1'b0, 0, f);
        check("timeout_state", {29'd0, state}, S_FAULT);
        fault_hold(2);
        do_reset();
        do_instr(NOP, TMO - 1, 0, 32'd0, 1'b0, 0, f);
        check("late_ready_pc", pc, RESET_PC + 32'd4);

        // Reset mid-EXEC and mid-FETCH
        goto(32'h20);
        check("exec_abort_pc_before", pc, 32'h20);
        do_instr(NOP, 0, 3, 32'd0, 1'b0, 2, f);
        check("exec_abort_pc", pc, RESET_PC);
        do_instr(NOP, TMO - 1, 0, 32'd0, 1'b0, 1, f);
        do_instr(NOP, TMO - 1, 0, 32'd0, 1'b0, 0, f);

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            ins  = $urandom;
            rs1  = $urandom;
            tk   = 1'($urandom);
            mis  = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 3);
            case (kind)
                0: case ($urandom_range(0, 5))
                       0: ins[6:0] = 7'h13;
                       1: ins[6:0] = 7'h33;
                       2: ins[6:0] = 7'h03;
                       3: ins[6:0] = 7'h23;
                       4: ins[6:0] = 7'h37;
                       default: ins[6:0] = 7'h17;
                   endcase
                1: begin
                    ins[6:0] = 7'h6F;
                    if (!mis) ins[21] = 1'b0;
                end
                2: begin
                    ins[6:0] = 7'h67;
                    if (!mis) begin
                        ins[21]  = 1'b0;
                        rs1[1:0] = 2'b00;
                    end
                end
                default: begin
                    ins[6:0] = 7'h63;
                    if (!mis) ins[8] = 1'b0;
                end
            endcase
            r  = $urandom_range(0, 9);
            fw = (r < 7) ? $urandom_range(0, 3) : (r == 7) ? TMO - 1 : (r == 8) ? TMO : 0;
            ew = $urandom_range(0, 3);
            ab = 0;
            r  = $urandom_range(0, 19);
            if (r == 0) begin
                ab = 1;
                fw = TMO - 1;
            end else if (r == 1) begin
                ab = 2;
                ew = 3;
            end
            do_instr(ins, fw, ew, rs1, tk, ab, f);
            if (f) begin
                fault_hold(2);
                do_reset();
            end
        end

        @(negedge clk);
        #1;
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
